mlt_arbiter: RTL and testbench

- Shares one complex multiplier (mlt_cplx, 48-bit packed operands) among NREQ requesters.
- Round-robin grant, one issue per cycle.
- Each requester's ID is tracked through the multiplier latency; results are buffered in a small FIFO with a valid/ready response port.
- Sits between the FFT/filter stage requesters and the single mlt_cplx instance.

---
 rtl/mlt_pkg.sv | 27 ++
 rtl/mlt_arbiter_if.sv | 33 +++
 rtl/mlt_rsp_fifo.sv | 59 +++++
 rtl/mlt_arbiter.sv | 112 +++++++++++
 tb/tb_mlt_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mlt_pkg.sv
// Shared definitions for the complex-multiplier arbiter: word type and the
// round-robin winner search.
package mlt_pkg;

    localparam int MLT_W       = 48;
    localparam int MLT_MAX_REQ = 32;
    localparam int MLT_IDX_W   = $clog2(MLT_MAX_REQ);

    typedef logic [MLT_W-1:0] mlt_word_t;

    // Returns the first set request after ptr (wrapping over nreq lanes), or -1.
    function automatic int rrPick(input logic [MLT_MAX_REQ-1:0] valid,
                                  input int ptr,
                                  input int nreq);
        int idx;
        int win;
        win = -1;
        for (int k = 1; k <= MLT_MAX_REQ; k++) begin
            idx = (ptr + k >= nreq) ? (ptr + k - nreq) : (ptr + k);
            if (k <= nreq && win < 0 && valid[idx[MLT_IDX_W-1:0]]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mlt_arbiter_if.sv
// Requester, multiplier and response signals of the shared multiplier arbiter.
interface mlt_arbiter_if
    import mlt_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = MLT_W
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      mlt_a;
    logic [W-1:0]      mlt_b;
    logic [W-1:0]      mlt_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_data;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, mlt_op, rsp_ready,
        output req_ready, mlt_a, mlt_b, rsp_valid, rsp_id, rsp_data, busy
    );

    modport master (
        output req_valid, req_a, req_b, mlt_op, rsp_ready,
        input  req_ready, mlt_a, mlt_b, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/mlt_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; head entry is held until popped.
module mlt_rsp_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pushEn_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             popReady_i,
    output logic             headValid_o,
    output logic [WIDTH-1:0] headData_o,
    output logic [CNTW-1:0]  count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [CNTW-1:0]  count_q;
    logic             doPush;
    logic             doPop;

    // A push at full is only accepted when the head leaves on the same edge.
    assign doPop  = (count_q != '0) && popReady_i;
    assign doPush = pushEn_i && ((count_q != CNTW'(DEPTH)) || doPop);

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= nextPtr(wrPtr_q);
            if (doPop)  rdPtr_q <= nextPtr(rdPtr_q);
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign headValid_o = (count_q != '0);
    assign headData_o  = mem_q[rdPtr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/mlt_arbiter.sv
// Round-robin arbiter sharing one complex multiplier, with requester-ID tagging
// through the multiplier latency and a credit-guarded response FIFO.
module mlt_arbiter
    import mlt_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int W          = MLT_W,
    parameter int MLT_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    mlt_arbiter_if.slave bus
);
    localparam int IDW  = $clog2(NREQ);
    localparam int FCW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW   = $clog2(FIFO_DEPTH + MLT_LAT + 1);

    logic [IDW-1:0]     rrPtr_q, rrPtr_d;
    logic [W-1:0]       mltA_q, mltA_d;
    logic [W-1:0]       mltB_q, mltB_d;
    logic [MLT_LAT-1:0] tagValid_q;
    logic [IDW-1:0]     tagId_q [MLT_LAT];

    int                 winIdx;
    logic [IDW-1:0]     winId;
    logic [NREQ-1:0]    reqReady;
    logic               issue;
    logic [W-1:0]       selA, selB;
    logic [CW-1:0]      inflight;
    logic               hasCredit;
    logic [FCW-1:0]     fifoCount;
    logic               fifoValid;
    logic [IDW+W-1:0]   fifoHead;

    assign winIdx = rrPick(MLT_MAX_REQ'(bus.req_valid), int'(rrPtr_q), NREQ);
    assign winId  = winIdx[IDW-1:0];

    // Every op in flight has a reserved FIFO slot, so results are never dropped.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < MLT_LAT; i++) begin
            inflight = inflight + CW'(tagValid_q[i]);
        end
        hasCredit = (CW'(fifoCount) + inflight) < CW'(FIFO_DEPTH);
    end

    always_comb begin
        reqReady = '0;
        if (!reset && hasCredit && winIdx >= 0) begin
            reqReady[winId] = 1'b1;
        end
        selA = '0;
        selB = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winIdx == i) begin
                selA = bus.req_a[i*W +: W];
                selB = bus.req_b[i*W +: W];
            end
        end
    end

    assign issue   = |reqReady;
    assign rrPtr_d = issue ? winId : rrPtr_q;
    assign mltA_d  = issue ? selA : mltA_q;
    assign mltB_d  = issue ? selB : mltB_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rrPtr_q    <= IDW'(NREQ - 1);
            mltA_q     <= '0;
            mltB_q     <= '0;
            tagValid_q <= '0;
            for (int i = 0; i < MLT_LAT; i++) begin
                tagId_q[i] <= '0;
            end
        end else begin
            rrPtr_q       <= rrPtr_d;
            mltA_q        <= mltA_d;
            mltB_q        <= mltB_d;
            tagValid_q[0] <= issue;
            tagId_q[0]    <= winId;
            for (int i = 1; i < MLT_LAT; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
                tagId_q[i]    <= tagId_q[i-1];
            end
        end
    end

    mlt_rsp_fifo #(
        .WIDTH (IDW + W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clock       (clock),
        .reset       (reset),
        .pushEn_i    (tagValid_q[MLT_LAT-1]),
        .pushData_i  ({tagId_q[MLT_LAT-1], bus.mlt_op}),
        .popReady_i  (bus.rsp_ready),
        .headValid_o (fifoValid),
        .headData_o  (fifoHead),
        .count_o     (fifoCount)
    );

    assign bus.req_ready = reqReady;
    assign bus.mlt_a     = mltA_q;
    assign bus.mlt_b     = mltB_q;
    assign bus.rsp_valid = fifoValid;
    assign bus.rsp_id    = fifoHead[IDW+W-1:W];
    assign bus.rsp_data  = fifoHead[W-1:0];
    assign bus.busy      = (|tagValid_q) || (fifoCount != '0);

endmodule

// File: tb/tb_mlt_arbiter.sv
// Directed bench for mlt_arbiter: one instance with a combinational XOR stand-in
// multiplier (latency 1) and one with a two-register XOR pipeline (latency 3).
module tb_mlt_arbiter;
    import mlt_pkg::*;

    logic clock = 1'b0;
    logic rst1  = 1'b1;
    logic rst3  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    mlt_arbiter_if #(.NREQ(4), .W(48)) bus1 ();
    mlt_arbiter_if #(.NREQ(4), .W(48)) bus3 ();

    mlt_arbiter #(.NREQ(4), .W(48), .MLT_LAT(1), .FIFO_DEPTH(4)) dut1 (
        .clock (clock),
        .reset (rst1),
        .bus   (bus1)
    );

    mlt_arbiter #(.NREQ(4), .W(48), .MLT_LAT(3), .FIFO_DEPTH(4)) dut3 (
        .clock (clock),
        .reset (rst3),
        .bus   (bus3)
    );

    // Stand-in multipliers: product is a XOR b, delayed MLT_LAT-1 registers.
    mlt_word_t stub3d1, stub3d2;
    assign bus1.mlt_op = bus1.mlt_a ^ bus1.mlt_b;
    always_ff @(posedge clock or posedge rst3) begin
        if (rst3) begin
            stub3d1 <= '0;
            stub3d2 <= '0;
        end else begin
            stub3d1 <= bus3.mlt_a ^ bus3.mlt_b;
            stub3d2 <= stub3d1;
        end
    end
    assign bus3.mlt_op = stub3d2;

    mlt_word_t opA [4];
    mlt_word_t opB [4];

    typedef struct {
        int         dutSel;
        bit         doRst;
        logic [3:0] reqValid;
        bit         rspReady;
        logic [3:0] expReady;
        bit         expRspValid;
        int         expId;
        bit         expBusy;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(input int d, input bit r, input logic [3:0] v,
                                   input bit rr, input logic [3:0] er, input bit ev,
                                   input int eid, input bit eb);
        vec_t x;
        x = '{d, r, v, rr, er, ev, eid, eb};
        vecs.push_back(x);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got,
                               input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx);
        vec_t       v;
        logic [3:0] gotReady;
        logic       gotValid;
        logic [1:0] gotId;
        logic [47:0] gotData;
        logic       gotBusy;
        v = vecs[idx];
        if (v.dutSel == 1) begin
            if (v.doRst) begin rst1 = 1'b1; #1; rst1 = 1'b0; end
            bus1.req_valid = v.reqValid;
            bus1.rsp_ready = v.rspReady;
            bus3.req_valid = 4'b0000;
            #1;
            gotReady = bus1.req_ready; gotValid = bus1.rsp_valid;
            gotId = bus1.rsp_id; gotData = bus1.rsp_data; gotBusy = bus1.busy;
        end else begin
            if (v.doRst) begin rst3 = 1'b1; #1; rst3 = 1'b0; end
            bus3.req_valid = v.reqValid;
            bus3.rsp_ready = v.rspReady;
            bus1.req_valid = 4'b0000;
            #1;
            gotReady = bus3.req_ready; gotValid = bus3.rsp_valid;
            gotId = bus3.rsp_id; gotData = bus3.rsp_data; gotBusy = bus3.busy;
        end
        checkOutput($sformatf("v%0d.req_ready", idx), 64'(gotReady), 64'(v.expReady));
        checkOutput($sformatf("v%0d.rsp_valid", idx), 64'(gotValid), 64'(v.expRspValid));
        checkOutput($sformatf("v%0d.busy", idx), 64'(gotBusy), 64'(v.expBusy));
        if (v.expRspValid) begin
            checkOutput($sformatf("v%0d.rsp_id", idx), 64'(gotId), 64'(v.expId));
            checkOutput($sformatf("v%0d.rsp_data", idx), 64'(gotData),
                        64'(opA[v.expId[1:0]] ^ opB[v.expId[1:0]]));
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        opA[0] = 48'h123456789ABC; opB[0] = 48'h0F0F0F0F0F0F;
        opA[1] = 48'h0000000000AA; opB[1] = 48'h0000000000F0;
        opA[2] = 48'hFFFF00000000; opB[2] = 48'h00FF00FF00FF;
        opA[3] = 48'hA5A5A5A5A5A5; opB[3] = 48'h5A5A5A5A5A5A;
        for (int i = 0; i < 4; i++) begin
            bus1.req_a[i*48 +: 48] = opA[i];
            bus1.req_b[i*48 +: 48] = opB[i];
            bus3.req_a[i*48 +: 48] = opA[i];
            bus3.req_b[i*48 +: 48] = opB[i];
        end
        bus1.req_valid = 4'b0000; bus1.rsp_ready = 1'b1;
        bus3.req_valid = 4'b0000; bus3.rsp_ready = 1'b1;

        // Single request (requester 1), latency-1 instance
        addVec(1, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        addVec(1, 1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0, 0, 1'b0);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b1);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1, 1'b1);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        // All four requesting continuously, consumer always ready
        addVec(1, 1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 0, 1'b0);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 0, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 0, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 1, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 3, 1'b1);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 0, 1'b1);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1, 1'b1);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        // Consumer stalled: four issues fill the credit, then drain in order
        addVec(1, 1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 0, 1'b0);
        addVec(1, 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0, 0, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 0, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b0, 4'b1000, 1'b1, 0, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 0, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 3, 1'b1);
        addVec(1, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 0, 1'b1);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1, 1'b1);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2, 1'b1);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 3, 1'b1);
        addVec(1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0);
        // Latency-3 instance, all four requesting
        addVec(3, 1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 0, 1'b0);
        addVec(3, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b0, 0, 1'b1);
        addVec(3, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b0, 0, 1'b1);
        addVec(3, 1'b0, 4'b1111, 1'b1, 4'b1000, 1'b0, 0, 1'b1);
        addVec(3, 1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 0, 1'b1);
        addVec(3, 1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1, 1'b1);
        addVec(3, 1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2, 1'b1);
        addVec(3, 1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 3, 1'b1);
        addVec(3, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b1);
        addVec(3, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 0, 1'b1);
        addVec(3, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1, 1'b1);
        addVec(3, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2, 1'b1);
        addVec(3, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0);

        // Reset state, with requests raised while reset is still held
        @(negedge clock);
        @(negedge clock);
        bus1.req_valid = 4'b1111;
        #1;
        checkOutput("rst.req_ready", 64'(bus1.req_ready), 64'h0);
        checkOutput("rst.rsp_valid", 64'(bus1.rsp_valid), 64'h0);
        checkOutput("rst.busy", 64'(bus1.busy), 64'h0);
        checkOutput("rst.mlt_a", 64'(bus1.mlt_a), 64'h0);
        checkOutput("rst.mlt_b", 64'(bus1.mlt_b), 64'h0);
        bus1.req_valid = 4'b0000;
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i);
        end

        // Asynchronous reset mid-burst: 2 results buffered, 2 still in flight
        rst3 = 1'b1; #1; rst3 = 1'b0;
        bus3.req_valid = 4'b1111;
        bus3.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        #1;
        checkOutput("mid.pre_rsp_valid", 64'(bus3.rsp_valid), 64'h1);
        checkOutput("mid.pre_busy", 64'(bus3.busy), 64'h1);
        rst3 = 1'b1;
        #1;
        checkOutput("mid.rsp_valid", 64'(bus3.rsp_valid), 64'h0);
        checkOutput("mid.req_ready", 64'(bus3.req_ready), 64'h0);
        checkOutput("mid.busy", 64'(bus3.busy), 64'h0);
        #1;
        rst3 = 1'b0;
        #1;
        checkOutput("mid.first_grant", 64'(bus3.req_ready), 64'h1);
        @(posedge clock);
        @(negedge clock);
        bus3.req_valid = 4'b0000;
        bus3.rsp_ready = 1'b1;
        #1;
        checkOutput("mid.mlt_a", 64'(bus3.mlt_a), 64'(opA[0]));
        checkOutput("mid.stale0", 64'(bus3.rsp_valid), 64'h0);
        for (int i = 1; i < 3; i++) begin
            @(posedge clock);
            @(negedge clock);
            #1;
            checkOutput($sformatf("mid.stale%0d", i), 64'(bus3.rsp_valid), 64'h0);
        end
        @(posedge clock);
        @(negedge clock);
        #1;
        checkOutput("mid.new_valid", 64'(bus3.rsp_valid), 64'h1);
        checkOutput("mid.new_id", 64'(bus3.rsp_id), 64'h0);
        checkOutput("mid.new_data", 64'(bus3.rsp_data), 64'(opA[0] ^ opB[0]));
        @(posedge clock);
        @(negedge clock);
        #1;
        checkOutput("mid.drained_valid", 64'(bus3.rsp_valid), 64'h0);
        checkOutput("mid.drained_busy", 64'(bus3.busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
